// File: rtl/assert_trk_pkg.sv
// Shared types, defaults and bit-vector helpers for the assertion result tracker.
package assert_trk_pkg;

    typedef enum logic {RUN, HALTED} trk_state_e;

    localparam int unsigned DefaultCntW = 16;
    localparam int unsigned DefaultCycW = 32;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int lowest_set_idx(input logic [15:0] vec);
        int idx;
        idx = 0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic int unsigned count_ones(input logic [15:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            n += {31'd0, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a programmable step, soft clear and synchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;
    logic [W:0]   sum;

    always_comb begin
        sum = {1'b0, q_q} + {1'b0, inc};
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = sum[W] ? '1 : sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/assert_result_tracker.sv
// Tallies per-check pass/fail results, latches the first failure and halts once the
// total-failure budget is reached; tallies are served through a one-cycle read port.
module assert_result_tracker
    import assert_trk_pkg::*;
#(
    parameter int unsigned NUM_CHK  = 3,
    parameter int unsigned CNT_W    = DefaultCntW,
    parameter int unsigned CYC_W    = DefaultCycW,
    parameter int unsigned MAX_FAIL = 4,
    parameter int unsigned IDX_W    = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CHK-1:0] chk_valid,
    input  logic [NUM_CHK-1:0] chk_pass,
    input  logic               clear,
    input  logic               rd_req,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_ack,
    output logic               rd_err,
    output logic [CNT_W-1:0]   rd_pass_cnt,
    output logic [CNT_W-1:0]   rd_fail_cnt,
    output logic               first_fail_vld,
    output logic [IDX_W-1:0]   first_fail_idx,
    output logic [CYC_W-1:0]   first_fail_cyc,
    output logic               any_fail,
    output logic               stop_req
);

    // Wide enough that total_fail can never saturate before the halt takes effect.
    localparam int unsigned TfW = $clog2(MAX_FAIL + NUM_CHK + 1);

    trk_state_e                    state_q, state_d;
    logic [NUM_CHK-1:0]            pass_vec, fail_vec;
    logic                          ev_en, halt;
    int unsigned                   nfail;
    logic [TfW:0]                  tf_sum;
    logic [TfW-1:0]                total_fail;
    logic [NUM_CHK-1:0][CNT_W-1:0] pass_cnt, fail_cnt;
    logic [CYC_W-1:0]              cyc_q, cyc_d;
    logic                          ff_vld_q, ff_vld_d, any_fail_q, any_fail_d;
    logic [IDX_W-1:0]              ff_idx_q, ff_idx_d;
    logic [CYC_W-1:0]              ff_cyc_q, ff_cyc_d;
    logic                          rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
    logic [CNT_W-1:0]              rd_pass_q, rd_pass_d, rd_fail_q, rd_fail_d;

    always_comb begin
        pass_vec = chk_valid & chk_pass;
        fail_vec = chk_valid & ~chk_pass;
        // Clear drops any events presented in the same cycle.
        ev_en    = (state_q == RUN) && !clear;
        nfail    = count_ones(16'(fail_vec));
        tf_sum   = {1'b0, total_fail} + (TfW + 1)'(nfail);
        halt     = ev_en && (tf_sum >= (TfW + 1)'(MAX_FAIL));
    end

    for (genvar i = 0; i < NUM_CHK; i++) begin : g_tally
        sat_counter #(.W(CNT_W)) u_pass (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (ev_en && pass_vec[i]),
            .clr   (clear),
            .inc   (CNT_W'(1)),
            .q     (pass_cnt[i])
        );
        sat_counter #(.W(CNT_W)) u_fail (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (ev_en && fail_vec[i]),
            .clr   (clear),
            .inc   (CNT_W'(1)),
            .q     (fail_cnt[i])
        );
    end

    sat_counter #(.W(TfW)) u_total_fail (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ev_en),
        .clr   (clear),
        .inc   (TfW'(nfail)),
        .q     (total_fail)
    );

    always_comb begin
        state_d = state_q;
        if (clear)     state_d = RUN;
        else if (halt) state_d = HALTED;

        cyc_d = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);

        ff_vld_d   = ff_vld_q;
        ff_idx_d   = ff_idx_q;
        ff_cyc_d   = ff_cyc_q;
        any_fail_d = any_fail_q | (ev_en && (|fail_vec));
        if (clear) begin
            ff_vld_d   = 1'b0;
            ff_idx_d   = '0;
            ff_cyc_d   = '0;
            any_fail_d = 1'b0;
        end else if (ev_en && !ff_vld_q && (|fail_vec)) begin
            ff_vld_d = 1'b1;
            ff_idx_d = IDX_W'(lowest_set_idx(16'(fail_vec)));
            ff_cyc_d = cyc_q;
        end

        // Read data reflects the tallies before this cycle's updates or clear.
        rd_ack_d  = rd_req;
        rd_err_d  = 1'b0;
        rd_pass_d = rd_pass_q;
        rd_fail_d = rd_fail_q;
        if (rd_req) begin
            if (32'(rd_idx) < NUM_CHK) begin
                rd_pass_d = pass_cnt[rd_idx];
                rd_fail_d = fail_cnt[rd_idx];
            end else begin
                rd_err_d  = 1'b1;
                rd_pass_d = '0;
                rd_fail_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cyc_q      <= '0;
            ff_vld_q   <= 1'b0;
            ff_idx_q   <= '0;
            ff_cyc_q   <= '0;
            any_fail_q <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_pass_q  <= '0;
            rd_fail_q  <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            ff_vld_q   <= ff_vld_d;
            ff_idx_q   <= ff_idx_d;
            ff_cyc_q   <= ff_cyc_d;
            any_fail_q <= any_fail_d;
            rd_ack_q   <= rd_ack_d;
            rd_err_q   <= rd_err_d;
            rd_pass_q  <= rd_pass_d;
            rd_fail_q  <= rd_fail_d;
        end
    end

    assign rd_ack         = rd_ack_q;
    assign rd_err         = rd_err_q;
    assign rd_pass_cnt    = rd_pass_q;
    assign rd_fail_cnt    = rd_fail_q;
    assign first_fail_vld = ff_vld_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_cyc = ff_cyc_q;
    assign any_fail       = any_fail_q;
    assign stop_req       = (state_q == HALTED);

endmodule
